// File: rtl/neuron_layer_eval.sv
// Sequential evaluator for a 4-neuron threshold layer. One shared adder
// accumulates bias plus gated weights, one accumulate per cycle.
module neuron_layer_eval #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [24*DATA_W-1:0]   params_flat,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             y_out,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIAS   = 3'd1,
    ST_WEIGHT = 3'd2,
    ST_CMP    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] FIELD_BIAS = 3'd4;
  localparam logic [2:0] FIELD_TH   = 3'd5;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  state_e             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [1:0]         neuron_q,    neuron_d;
  logic [1:0]         step_q,      step_d;
  logic [3:0]         x_q,         x_d;
  logic [3:0]         y_q,         y_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;
  logic               in_ready_q,  in_ready_d;

  logic [DATA_W-1:0]  param_bytes_s [24];
  logic [2:0]         field_s;
  logic [4:0]         byte_idx_s;
  logic [DATA_W-1:0]  sel_byte_s;
  logic [ACC_W-1:0]   operand_s;
  logic [ACC_W-1:0]   acc_base_s;
  logic [ACC_W-1:0]   addend_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic               ge_s;

  genvar gk;
  generate
    for (gk = 0; gk < 24; gk++) begin : g_unpack
      assign param_bytes_s[gk] = params_flat[gk*DATA_W +: DATA_W];
    end
  endgenerate

  // Pick the parameter field the current state consumes.
  always_comb begin
    field_s = 3'd0;
    case (state_q)
      ST_BIAS:   field_s = FIELD_BIAS;
      ST_WEIGHT: field_s = {1'b0, step_q};
      ST_CMP:    field_s = FIELD_TH;
      default:   field_s = 3'd0;
    endcase
  end

  // Byte index 6*n + f, built as 4n + 2n + f.
  assign byte_idx_s = {1'b0, neuron_q, 2'b00} + {2'b00, neuron_q, 1'b0} + {2'b00, field_s};
  assign sel_byte_s = param_bytes_s[byte_idx_s];
  assign operand_s  = sext(sel_byte_s);

  // Shared adder operands: BIAS loads b_n via a zero base, WEIGHT adds the gated weight.
  always_comb begin
    acc_base_s = acc_q;
    addend_s   = {ACC_W{1'b0}};
    case (state_q)
      ST_BIAS: begin
        acc_base_s = {ACC_W{1'b0}};
        addend_s   = operand_s;
      end
      ST_WEIGHT: begin
        if (x_q[step_q]) begin
          addend_s = operand_s;
        end else begin
          addend_s = {ACC_W{1'b0}};
        end
      end
      default: begin
        acc_base_s = acc_q;
        addend_s   = {ACC_W{1'b0}};
      end
    endcase
  end

  assign acc_sum_s = acc_base_s + addend_s;
  assign ge_s      = ($signed(acc_q) >= $signed(operand_s));

  // Next-state and registered-output logic for the evaluation sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    neuron_d    = neuron_q;
    step_d      = step_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = x_in;
          y_d        = 4'b0000;
          neuron_d   = 2'd0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = ST_BIAS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BIAS: begin
        acc_d   = acc_sum_s;
        step_d  = 2'd0;
        state_d = ST_WEIGHT;
      end
      ST_WEIGHT: begin
        acc_d = acc_sum_s;
        if (step_q == 2'd3) begin
          state_d = ST_CMP;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_CMP: begin
        y_d[neuron_q] = ge_s;
        if (neuron_q == 2'd3) begin
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end else begin
          neuron_d = neuron_q + 2'd1;
          state_d  = ST_BIAS;
        end
      end
      ST_DONE: begin
        // in_valid is ignored here; the earliest new accept is the cycle after the handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        acc_d       = {ACC_W{1'b0}};
        neuron_d    = 2'd0;
        step_d      = 2'd0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      neuron_q    <= 2'd0;
      step_q      <= 2'd0;
      x_q         <= 4'b0000;
      y_q         <= 4'b0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      neuron_q    <= neuron_d;
      step_q      <= step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_layer_eval.sv
// Self-checking bench for neuron_layer_eval: vector table plus corner sequences,
// expected spike vectors queued at accept and compared when out_valid rises.
module tb_neuron_layer_eval;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 11;
  localparam int PW     = 24*DATA_W;

  typedef struct {
    logic [PW-1:0] params;
    logic [3:0]    x;
    logic [3:0]    y;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] params_flat;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    x_in;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    y_out;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb_q[$];
  logic [3:0] last_y;

  neuron_layer_eval #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .params_flat(params_flat),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] set_nrn(input logic [PW-1:0] p, input int n,
      input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
      input logic [7:0] w3, input logic [7:0] b, input logic [7:0] th);
    logic [PW-1:0] r;
    r = p;
    r[(6*n+0)*8 +: 8] = w0;
    r[(6*n+1)*8 +: 8] = w1;
    r[(6*n+2)*8 +: 8] = w2;
    r[(6*n+3)*8 +: 8] = w3;
    r[(6*n+4)*8 +: 8] = b;
    r[(6*n+5)*8 +: 8] = th;
    return r;
  endfunction

  function automatic logic [PW-1:0] uni(input logic [7:0] w, input logic [7:0] b, input logic [7:0] th);
    logic [PW-1:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) r = set_nrn(r, n, w, w, w, w, b, th);
    return r;
  endfunction

  // Integer reference model of the layer.
  function automatic logic [3:0] ref_eval(input logic [PW-1:0] p, input logic [3:0] x);
    logic [3:0] y;
    int acc;
    byte bv;
    y = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      bv  = p[(6*n+4)*8 +: 8];
      acc = int'(bv);
      for (int i = 0; i < 4; i++) begin
        if (x[i]) begin
          bv  = p[(6*n+i)*8 +: 8];
          acc = acc + int'(bv);
        end
      end
      bv   = p[(6*n+5)*8 +: 8];
      y[n] = (acc >= int'(bv));
    end
    return y;
  endfunction

  task automatic start(input logic [PW-1:0] p, input logic [3:0] x, input logic [3:0] exp);
    int n;
    params_flat = p;
    x_in        = x;
    in_valid    = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_drop", {31'd0, in_ready}, 32'd0);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("y_cleared", {28'd0, y_out}, 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int edges;
    logic [3:0] exp;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (out_valid !== 1'b1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, edges, 32'd24);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_y"}, {28'd0, y_out}, {28'd0, exp});
      last_y = exp;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_hs_y_held"}, {28'd0, y_out}, {28'd0, last_y});
  endtask

  vec_t vecs[8];

  initial begin
    logic [PW-1:0] p_ext;
    logic [PW-1:0] p_gate;
    logic [PW-1:0] p_rand;
    logic [3:0]    x_rand;
    logic [3:0]    dummy;

    p_ext  = '0;
    p_ext  = set_nrn(p_ext, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00);
    p_ext  = set_nrn(p_ext, 1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    p_gate = uni(8'h00, 8'h00, 8'h01);
    p_gate = set_nrn(p_gate, 2, 8'd10, 8'd100, 8'd10, 8'd100, 8'hF1, 8'h05);

    vecs[0] = '{params: uni(8'h01, 8'h00, 8'h04), x: 4'b1111, y: 4'b1111};
    vecs[1] = '{params: uni(8'h01, 8'h00, 8'h05), x: 4'b1111, y: 4'b0000};
    vecs[2] = '{params: p_ext,                    x: 4'b1111, y: 4'b1110};
    vecs[3] = '{params: p_gate,                   x: 4'b0101, y: 4'b0100};
    vecs[4] = '{params: set_nrn(p_gate, 2, 8'd10, 8'd100, 8'd10, 8'd100, 8'hF1, 8'h06),
                x: 4'b0101, y: 4'b0000};
    vecs[5] = '{params: uni(8'h01, 8'h00, 8'h01), x: 4'b1000, y: 4'b1111};
    vecs[6] = '{params: uni(8'h01, 8'h00, 8'h02), x: 4'b1000, y: 4'b0000};
    vecs[7] = '{params: uni(8'hFF, 8'h00, 8'hFD), x: 4'b0111, y: 4'b1111};

    // Reset with in_valid held high: nothing may be accepted.
    reset       = 1'b1;
    in_valid    = 1'b1;
    x_in        = 4'b1111;
    out_ready   = 1'b0;
    params_flat = uni(8'h01, 8'h00, 8'h04);
    last_y      = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", {28'd0, y_out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].params, vecs[i].x, vecs[i].y);
      wait_result($sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      p_rand = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      x_rand = 4'($urandom_range(0, 15));
      start(p_rand, x_rand, ref_eval(p_rand, x_rand));
      wait_result($sformatf("rnd%0d", i));
      handshake($sformatf("rnd%0d", i));
    end

    // Backpressure: hold the result for 10 cycles while in_valid pulses.
    start(uni(8'h01, 8'h00, 8'h04), 4'b1111, 4'b1111);
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x_in     = 4'b0000;
      @(negedge clk);
      chk("bp_y_stable", {28'd0, y_out}, 32'hF);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_busy_low", {31'd0, busy}, 32'd0);
    end
    params_flat = p_ext;
    x_in        = 4'b1111;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_no_accept_in_done", {31'd0, busy}, 32'd0);
    start(p_ext, 4'b1111, 4'b1110);
    wait_result("b2b");
    handshake("b2b");

    // Reset at E10 discards the evaluation.
    start(uni(8'h01, 8'h00, 8'h04), 4'b1111, 4'b1111);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_y", {28'd0, y_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    if (sb_q.size() != 0) dummy = sb_q.pop_back();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    start(uni(8'h01, 8'h00, 8'h04), 4'b1111, 4'b1111);
    wait_result("post_rst");
    handshake("post_rst");

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_layer_eval.md
Name: neuron_layer_eval

Overview:
- Sequential evaluator for the 4-neuron threshold layer.
- Consumes the 24 parameter bytes held by the parameter shift register: per neuron, 4 weights, a bias and a threshold.
- Accepts a 4-bit binary input spike vector over a valid/ready handshake and produces a 4-bit output spike vector.
- Uses one accumulate per cycle, so one adder is shared by all neurons.
- Sits directly downstream of the parameter register and feeds the layer-output logic.

Parameters:
- DATA_W, 8, width of each weight/bias/threshold byte; signed two's complement.
- ACC_W, 11, accumulator width; must be >= DATA_W+3; holds -640..635 without overflow.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- params_flat  input  24*DATA_W  packed parameters. Byte k = params_flat[8k+7:8k], with k = 6*n + f for neuron n = 0..3. Field f: 0..3 = w_n0..w_n3, 4 = b_n, 5 = th_n.
- in_valid  input  1  x_in is valid.
- in_ready  output  1  block can accept x_in.
- x_in  input  4  input spike vector; bit i gates weight w_ni.
- out_valid  output  1  y_out is valid.
- out_ready  input  1  consumer accepts y_out.
- y_out  output  4  output spike vector; bit n belongs to neuron n.
- busy  output  1  evaluation in progress; upstream control must not shift parameters while busy or out_valid is high.

Behaviour:
- Reset (synchronous, active-high): state IDLE, accumulator 0, neuron counter 0, step counter 0, captured x 0. Outputs: y_out=0, out_valid=0, busy=0, in_ready=1.
- Reset overrides everything on any edge, including mid-evaluation: the partial result is discarded and no out_valid is produced.
- States: IDLE, BIAS, WEIGHT, CMP, DONE.
- IDLE: in_ready=1, busy=0. On in_valid&&in_ready:
  - capture x_in;
  - clear y_out;
  - set neuron=0;
  - go to BIAS.
- BIAS: acc <= sign-extended b_n; step=0; go to WEIGHT. busy=1.
- WEIGHT: 4 cycles, step 0..3. Each cycle acc <= acc + (x[step] ? sext(w_n,step) : 0). After step 3, go to CMP.
- CMP: y_out[n] <= (acc >= sext(th_n)), signed compare.
  - If n<3: n <= n+1, go to BIAS.
  - If n=3: go to DONE, out_valid <= 1, busy <= 0.
- Timing: each neuron takes 6 edges. Counting the accept edge as E0, out_valid is high after E24 and y_out is final at the same time.
- DONE: out_valid=1 and y_out held stable until out_ready is sampled high. On that edge, go to IDLE and set out_valid=0.
  - In DONE, in_ready=0 and in_valid is ignored. No accept in the same cycle as the handshake; the earliest new accept is the following cycle.
- in_ready is 0 in every state except IDLE. in_valid is ignored while busy.
- Arithmetic: no saturation, because ACC_W guarantees no overflow. A -128 weight (0x80) is a valid operand.
- params_flat is read combinationally during BIAS/WEIGHT/CMP and is not snapshotted. Results are undefined if it changes while busy=1.
- y_out keeps the last result in IDLE until the next accept clears it.

Test Plan:
- Reset: assert reset 2 cycles -> y_out=0, out_valid=0, busy=0, in_ready=1. Holding in_valid=1 during reset -> nothing accepted.
- Uniform: all w=0x01, b=0x00, th=0x04, x_in=4'b1111 -> in_ready drops after accept, busy=1 for E1..E24. out_valid=1 after E24 with y_out=4'b1111. Repeat with th=0x05 -> y_out=4'b0000.
- Extremes, x_in=4'b1111:
  - neuron0 all fields 0x80 except th0=0x00 -> acc=-640, y_out[0]=0;
  - neuron1 all fields 0x7F -> acc=635 >= 127, y_out[1]=1;
  - neurons 2/3 zero params -> acc=0 >= 0, spike.
  - Expected y_out=4'b1110.
- Gating: x_in=4'b0101, neuron2 w=(10,100,10,100), b=-15 (0xF1), th=5 -> acc=5, y_out[2]=1. With th=6 -> y_out[2]=0. Neurons 0/1/3 with b=0x00, th=0x01, w=0 -> their bits 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> y_out and out_valid stable, in_ready=0, pulsing in_valid has no effect. Raise out_ready -> next cycle out_valid=0, in_ready=1. Back-to-back accept on that cycle -> new result 24 edges later.
- Mid-op reset: reset at E10 -> next cycle IDLE, y_out=0, busy=0, no out_valid. A following evaluation with the uniform vector -> y_out=4'b1111 at E24.
